argmax_select: RTL
==================

# argmax_select

Classification stage directly downstream of the output layer. It consumes the serialized stream of signed neuron scores, one score per enabled cycle, and tracks the running maximum and its index across a frame of `NEU_NUM` beats. At frame end it registers the winning class index and score and pulses `done`. It is the last datapath stage before the result is handed to the host/display logic.

## Interface
Parameters:
- `FEATURE_WIDE`, 4: feature width term; score width `DATA_W = FEATURE_WIDE+16`.
- `NEU_NUM`, 8: beats (classes) per frame; legal range 2..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  beat valid; `result` is sampled when high.
- `result`  in  DATA_W  signed score for the current beat.
- `flag_begin`  in  1  frame restart marker; only acted on when `en=1`.
- `class_idx`  out  4  index (0-based) of the winning beat.
- `max_val`  out  DATA_W  signed winning score.
- `margin`  out  DATA_W+1  winner minus runner-up, non-negative. Present only with `ARGMAX_MARGIN_EN`.
- `busy`  out  1  high while a frame is partially accumulated.
- `done`  out  1  one-cycle pulse; outputs are valid from this cycle.

## Operation
- States: IDLE, ACC.
- **IDLE:** a beat (`en=1`) is beat 0.
  - Load `cur_max=result`, `cur_idx=0`, `cnt=1`.
  - Runner-up is initialised to the most negative DATA_W value.
  - Go to ACC.
- **ACC:** each beat is beat `cnt`.
  - If `result > cur_max` (signed, strict): runner-up ← `cur_max`, `cur_max` ← `result`, `cur_idx` ← `cnt`.
  - Otherwise, if `result > runner-up`: runner-up ← `result`.
  - `cnt` increments on each beat.
- Ties keep the lower index. An equal value still becomes runner-up, so margin is 0.
- **Frame end:** on beat `NEU_NUM-1`, the final compare result is written into `class_idx`/`max_val`/`margin`, `done` is set for the next cycle, and the state returns to IDLE.
- **Output hold:** outputs hold until the next `done`. Internal accumulators never appear on the outputs mid-frame.
- **Restart:** `flag_begin=1` with `en=1` in any state treats that beat as beat 0. A partial frame is discarded with no `done`.
- **Gaps:** `en=0` cycles pause accumulation indefinitely. There is no timeout.
- **Back-to-back frames:** a beat arriving in the same cycle `done` is high is beat 0 of the next frame.
- **Reset:** asynchronous assertion at any time clears the state to IDLE, `cnt=0`, and all outputs to 0 (`class_idx=0`, `max_val=0`, `margin=0`, `busy=0`, `done=0`). A partial frame is lost.
- **Arithmetic:**
  - All compares are signed at DATA_W.
  - `margin` is computed in DATA_W+1 bits by sign-extending both operands, so there is no overflow.

## Timing
- Beat k is sampled at the rising edge where `en=1`. The update is visible in internal state after that edge.
- With contiguous beats at cycles 0..NEU_NUM-1, `done` is high in cycle NEU_NUM (1-cycle latency after the last beat). Outputs change in the same cycle.
- `busy` rises the cycle after beat 0 and falls in the cycle `done` is high.
- `done` is never high for two consecutive cycles.

## Configuration
- `ARGMAX_MARGIN_EN` defined: runner-up register, margin subtractor and the `margin` port are present.
- `ARGMAX_MARGIN_EN` undefined: runner-up logic and the `margin` port are removed. `class_idx`, `max_val`, `done`, `busy` and their timing are identical.

## Test plan
All scenarios use default parameters (DATA_W=20, NEU_NUM=8).
- **Tie:** contiguous frame [3,-5,10,7,10,2,-1,0] → `done` in cycle 8, `class_idx=2`, `max_val=10`, `margin=0`.
- **All negative:** frame [-8,-3,-9,-4,-100,-6,-50,-7] → `class_idx=1`, `max_val=-3`, `margin=1`.
- **Gaps:** same frame as scenario 1 with `en` alternating 1,0 → identical outputs; `done` exactly 1 cycle after the 8th beat; `busy` high throughout.
- **Restart:** beats [100,100,100], then `flag_begin=1` with frame [1,2,3,4,5,6,7,8] → one `done`, `class_idx=7`, `max_val=8`, `margin=1`.
- **Reset mid-frame:** `rst_n` pulsed low after beat 4 → outputs 0 immediately, no `done`; the next full frame [0,0,0,0,0,0,0,-1] gives `class_idx=0`, `max_val=0`.
- **Extremes, back-to-back:** frame 1 = [-524288 ×7, 524287] then frame 2 starting in the `done` cycle = [524287, -524288 ×7]. Expect two `done` pulses 8 cycles apart, giving `class_idx` 7 then 0 and `margin=1048575` both times.

Source files
------------

// File: rtl/argmax_select_if.sv
// Score-stream and classification-result bundle for argmax_select.
// The margin signal exists only when ARGMAX_MARGIN_EN is defined.
interface argmax_select_if #(
  parameter int DATA_W = 20
);
  logic                     en;
  logic signed [DATA_W-1:0] result;
  logic                     flag_begin;
  logic [3:0]               class_idx;
  logic signed [DATA_W-1:0] max_val;
`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_W:0]   margin;
`endif
  logic                     busy;
  logic                     done;

`ifdef ARGMAX_MARGIN_EN
  modport master (output en, result, flag_begin,
                  input  class_idx, max_val, margin, busy, done);
  modport slave  (input  en, result, flag_begin,
                  output class_idx, max_val, margin, busy, done);
`else
  modport master (output en, result, flag_begin,
                  input  class_idx, max_val, busy, done);
  modport slave  (input  en, result, flag_begin,
                  output class_idx, max_val, busy, done);
`endif
endinterface

// File: rtl/argmax_select.sv
// argmax_select: running signed maximum and its index over a frame of
// NEU_NUM score beats; registers the winner and pulses done at frame end.
// Optional feature macro: ARGMAX_MARGIN_EN (runner-up tracking and margin).
//
// state | meaning
// IDLE  | waiting for beat 0 of a frame
// ACC   | frame partially accumulated, cnt = index of the next beat
module argmax_select #(
  parameter int FEATURE_WIDE = 4,
  parameter int NEU_NUM      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  argmax_select_if.slave bus
);
  localparam int DATA_W = FEATURE_WIDE + 16;
  localparam logic [3:0] LAST_BEAT = 4'(NEU_NUM - 1);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                   state, state_nx;
  logic [3:0]               cnt, cnt_nx;
  logic signed [DATA_W-1:0] cur_max, cur_max_nx;
  logic [3:0]               cur_idx, cur_idx_nx;
  logic [3:0]               class_q, class_nx;
  logic signed [DATA_W-1:0] max_q, max_nx;
  logic                     done_q, done_nx;

  logic                     new_max;
  logic signed [DATA_W-1:0] upd_max;
  logic [3:0]               upd_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W-1:0] run_max, run_max_nx, upd_run;
  logic signed [DATA_W:0]   margin_q, margin_nx, upd_margin;
`endif

  // Candidate winner (and runner-up) after folding in the current beat.
  always_comb begin
    new_max = bus.result > cur_max;
    upd_max = new_max ? bus.result : cur_max;
    upd_idx = new_max ? cnt : cur_idx;
`ifdef ARGMAX_MARGIN_EN
    upd_run = run_max;
    if (new_max)
      upd_run = cur_max;
    else if (bus.result > run_max)
      upd_run = bus.result;
    // Sign-extended by one bit so extreme operands cannot overflow.
    upd_margin = {upd_max[DATA_W-1], upd_max} - {upd_run[DATA_W-1], upd_run};
`endif
  end

  // Next-state, accumulator and output-register update.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cur_max_nx = cur_max;
    cur_idx_nx = cur_idx;
    class_nx   = class_q;
    max_nx     = max_q;
    done_nx    = 1'b0;
`ifdef ARGMAX_MARGIN_EN
    run_max_nx = run_max;
    margin_nx  = margin_q;
`endif
    if (bus.en) begin
      if (bus.flag_begin || state == IDLE) begin
        // Beat 0: any partial frame is simply overwritten.
        state_nx   = ACC;
        cnt_nx     = 4'd1;
        cur_max_nx = bus.result;
        cur_idx_nx = 4'd0;
`ifdef ARGMAX_MARGIN_EN
        run_max_nx = MOST_NEG;
`endif
      end else if (cnt == LAST_BEAT) begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
        class_nx = upd_idx;
        max_nx   = upd_max;
        done_nx  = 1'b1;
`ifdef ARGMAX_MARGIN_EN
        margin_nx = upd_margin;
`endif
      end else begin
        cnt_nx     = cnt + 4'd1;
        cur_max_nx = upd_max;
        cur_idx_nx = upd_idx;
`ifdef ARGMAX_MARGIN_EN
        run_max_nx = upd_run;
`endif
      end
    end
  end

  // State, accumulators and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_max <= '0;
      cur_idx <= '0;
      class_q <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur_max <= cur_max_nx;
      cur_idx <= cur_idx_nx;
      class_q <= class_nx;
      max_q   <= max_nx;
      done_q  <= done_nx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // Runner-up and margin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max  <= '0;
      margin_q <= '0;
    end else begin
      run_max  <= run_max_nx;
      margin_q <= margin_nx;
    end
  end

  assign bus.margin = margin_q;
`endif

  assign bus.class_idx = class_q;
  assign bus.max_val   = max_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == ACC);

endmodule
